// File: rtl/port_io_ctrl_pkg.sv
// Shared types and constants for the CPU-to-I/O-port sequencer.
package port_io_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  localparam int IO_DW = 8;
  localparam int IO_NPORTS = 16;
  localparam logic [IO_DW-1:0] IO_ERR_DATA = 8'hFF;

endpackage

// File: rtl/port_io_ctrl_if.sv
// CPU-side request/response bus of the I/O port sequencer.
interface port_io_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_err;
  logic          cpu_busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err, cpu_busy
  );
endinterface

// File: rtl/port_io_ctrl_sync.sv
// Generic multi-flop synchroniser for asynchronous inputs, cleared on reset.
module port_io_ctrl_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/port_io_ctrl.sv
// Sequences single CPU IN/OUT transactions onto 16 registered output ports
// and 16 synchronised input ports with per-port strobe/valid handshakes.
module port_io_ctrl
  import port_io_ctrl_pkg::*;
#(
  parameter int NPORTS      = IO_NPORTS,
  parameter int DW          = IO_DW,
  parameter int AW          = $clog2(NPORTS),
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  port_io_ctrl_if.slave               bus,
  input  logic [NPORTS-1:0][DW-1:0]   port_in,
  input  logic [NPORTS-1:0]           in_valid,
  output logic [NPORTS-1:0]           in_take,
  output logic [NPORTS-1:0][DW-1:0]   port_out,
  output logic [NPORTS-1:0]           out_strobe
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                     state, state_nxt;
  logic [AW-1:0]              addr_q;
  logic [DW-1:0]              wdata_q;
  logic [CW-1:0]              cnt;
  logic [NPORTS-1:0]          vsync;
  logic [NPORTS-1:0][DW-1:0]  dsync;
  logic                       addr_ok;
  logic                       rd_hit;
  logic                       rd_tmo;

  // Valid and data share one synchroniser so they arrive on the same cycle.
  port_io_ctrl_sync #(
    .W      (NPORTS * (DW + 1)),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({in_valid, port_in}),
    .q     ({vsync, dsync})
  );

  assign addr_ok = int'(addr_q) < NPORTS;
  assign rd_hit  = addr_ok && vsync[addr_q];
  // Unmapped addresses complete immediately as an error read.
  assign rd_tmo  = !addr_ok || (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_nxt = bus.cpu_we ? WRITE : READ;
      WRITE:   state_nxt = ACK;
      READ:    if (rd_hit || rd_tmo) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      port_out      <= '0;
      out_strobe    <= '0;
      in_take       <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_busy  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.cpu_ack  <= (state_nxt == ACK);
      bus.cpu_busy <= (state_nxt != IDLE);
      out_strobe   <= '0;
      in_take      <= '0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            cnt     <= '0;
          end
        end
        WRITE: begin
          bus.cpu_err <= 1'b0;
          if (addr_ok) begin
            port_out[addr_q]   <= wdata_q;
            out_strobe[addr_q] <= 1'b1;
          end
        end
        READ: begin
          if (rd_hit) begin
            bus.cpu_rdata   <= dsync[addr_q];
            bus.cpu_err     <= 1'b0;
            in_take[addr_q] <= 1'b1;
          end else if (rd_tmo) begin
            bus.cpu_rdata <= IO_ERR_DATA;
            bus.cpu_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_port_io_ctrl.sv
// Directed and randomised checks of port_io_ctrl against a port-array model.
module tb_port_io_ctrl;

  localparam int NP      = 16;
  localparam int SS      = 2;
  localparam int TIMEOUT = 64;

  logic                 clk;
  logic                 reset;
  logic [NP-1:0][7:0]   port_in;
  logic [NP-1:0]        in_valid;
  logic [NP-1:0]        in_take;
  logic [NP-1:0][7:0]   port_out;
  logic [NP-1:0]        out_strobe;

  port_io_ctrl_if #(.AW(4), .DW(8)) bus ();

  port_io_ctrl #(
    .NPORTS(NP), .DW(8), .AW(4), .SYNC_STAGES(SS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .port_in    (port_in),
    .in_valid   (in_valid),
    .in_take    (in_take),
    .port_out   (port_out),
    .out_strobe (out_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected contents of the output port array.
  logic [NP-1:0][7:0] mem;

  // Results of the most recent transaction.
  int         r_lat;
  logic [7:0] r_rd;
  logic       r_err;
  logic       r_busy1;
  int         r_take_a, r_take_o, r_strb_a, r_strb_o;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally raising in_valid[a] at cycle rise_at, and
  // collect latency, response and per-port pulse counts until ack.
  task automatic txn(input logic we, input logic [3:0] a, input logic [7:0] d,
                     input int rise_at, input logic [7:0] rise_d);
    bit done;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    done = 0; r_lat = -1; r_rd = 'x; r_err = 'x;
    r_take_a = 0; r_take_o = 0; r_strb_a = 0; r_strb_o = 0;
    r_busy1 = bus.cpu_busy;
    for (int k = 1; k <= TIMEOUT + 20 && !done; k++) begin
      if (k > 1) @(negedge clk);
      r_take_a += int'(in_take[a]);
      r_take_o += $countones(in_take) - int'(in_take[a]);
      r_strb_a += int'(out_strobe[a]);
      r_strb_o += $countones(out_strobe) - int'(out_strobe[a]);
      if (bus.cpu_ack) begin
        done = 1; r_lat = k; r_rd = bus.cpu_rdata; r_err = bus.cpu_err;
      end
      if (k == rise_at) begin
        in_valid[a] = 1'b1; port_in[a] = rise_d;
      end
    end
    chk("ack_seen", done, 1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ack"},   bus.cpu_ack, 0);
    chk({tag, "_err"},   bus.cpu_err, 0);
    chk({tag, "_busy"},  bus.cpu_busy, 0);
    chk({tag, "_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_take"},  in_take, 0);
    chk({tag, "_strb"},  out_strobe, 0);
    chk({tag, "_pout"},  port_out, 0);
  endtask

  initial begin
    int acks, a1, a2, strb0;
    logic       we, ready;
    logic [3:0] a;
    logic [7:0] d, exp_rd;

    reset = 1'b1;
    port_in = '0; in_valid = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    mem = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: single write
    txn(1'b1, 4'd3, 8'hA5, -1, 8'h00);
    mem[3] = 8'hA5;
    chk("w1_lat", r_lat, 2);
    chk("w1_busy", r_busy1, 1);
    chk("w1_strb", r_strb_a, 1);
    chk("w1_strb_other", r_strb_o, 0);
    chk("w1_pout", port_out, mem);

    // 2: ready read
    @(negedge clk);
    in_valid[7] = 1'b1; port_in[7] = 8'h3C;
    repeat (SS + 1) @(negedge clk);
    txn(1'b0, 4'd7, 8'h00, -1, 8'h00);
    chk("r2_lat", r_lat, 2);
    chk("r2_data", r_rd, 8'h3C);
    chk("r2_err", r_err, 0);
    chk("r2_take", r_take_a, 1);
    chk("r2_take_other", r_take_o, 0);
    in_valid[7] = 1'b0;
    repeat (SS + 1) @(negedge clk);

    // 3: timed-out read
    txn(1'b0, 4'd9, 8'h00, -1, 8'h00);
    chk("r3_lat", r_lat, TIMEOUT + 1);
    chk("r3_data", r_rd, 8'hFF);
    chk("r3_err", r_err, 1);
    chk("r3_take", r_take_a + r_take_o, 0);

    // 4: request held high, back-to-back writes to port 0
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'd0; bus.cpu_wdata = 8'h01;
    acks = 0; a1 = -1; a2 = -1; strb0 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      strb0 += int'(out_strobe[0]);
      if (bus.cpu_ack) begin
        acks++;
        if (acks == 1) begin a1 = k; bus.cpu_wdata = 8'h02; end
        else if (acks == 2) begin a2 = k; bus.cpu_req = 1'b0; end
      end
    end
    bus.cpu_req = 1'b0;
    mem[0] = 8'h02;
    chk("b2b_acks", acks, 2);
    chk("b2b_first", a1, 2);
    chk("b2b_period", a2 - a1, 3);
    chk("b2b_strb", strb0, 2);
    chk("b2b_pout", port_out, mem);

    // 5: reset while in WRITE
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'd2; bus.cpu_wdata = 8'h77;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    chk_idle_zero("rstw");
    @(negedge clk);
    chk("rstw_hold_ack", bus.cpu_ack, 0);
    chk("rstw_hold_pout2", port_out[2], 8'h00);
    reset = 1'b0;
    mem = '0;
    @(negedge clk);
    txn(1'b1, 4'd2, 8'h77, -1, 8'h00);
    mem[2] = 8'h77;
    chk("rstw_after_lat", r_lat, 2);
    chk("rstw_after_pout", port_out, mem);

    // 6: in_valid rises while a read is pending
    txn(1'b0, 4'd5, 8'h00, 10, 8'h5A);
    chk("late_min", (r_lat - 10) >= SS + 1, 1);
    chk("late_max", (r_lat - 10) <= SS + 2, 1);
    chk("late_data", r_rd, 8'h5A);
    chk("late_err", r_err, 0);
    chk("late_take", r_take_a, 1);
    in_valid[5] = 1'b0;
    repeat (SS + 1) @(negedge clk);

    // Randomised transactions against the model
    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, NP - 1));
      d  = 8'($urandom_range(0, 255));
      if (we) begin
        txn(1'b1, a, d, -1, 8'h00);
        mem[a] = d;
        chk("rnd_w_lat", r_lat, 2);
        chk("rnd_w_err", r_err, 0);
        chk("rnd_w_strb", r_strb_a, 1);
        chk("rnd_w_strb_other", r_strb_o, 0);
        chk("rnd_w_pout", port_out, mem);
      end else begin
        ready = ($urandom_range(0, 2) != 0);
        if (ready) begin
          in_valid[a] = 1'b1; port_in[a] = d;
          repeat (SS + 1) @(negedge clk);
        end
        exp_rd = ready ? d : 8'hFF;
        txn(1'b0, a, 8'h00, -1, 8'h00);
        chk("rnd_r_lat", r_lat, ready ? 2 : TIMEOUT + 1);
        chk("rnd_r_data", r_rd, exp_rd);
        chk("rnd_r_err", r_err, !ready);
        chk("rnd_r_take", r_take_a, ready ? 1 : 0);
        chk("rnd_r_take_other", r_take_o, 0);
        chk("rnd_r_pout", port_out, mem);
        if (ready) begin
          in_valid[a] = 1'b0;
          repeat (SS + 1) @(negedge clk);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
